pattern_stream_tx: RTL and testbench
====================================

# pattern_stream_tx

Serial pattern transmitter that drives the single-bit stream a sequence detector consumes. It accepts a parallel pattern and a repetition count over a valid/ready handshake. It then shifts the pattern out MSB-first, one bit per clock, for the requested number of repetitions, inserting idle gaps between repetitions. It is the stimulus and transmit end of the `0110` bit-stream detection path and is used both in-system and as the bench driver for the detector.

## Interface
- `PATTERN_W`, 4: pattern length in bits, range 2..16.
- `DEFAULT_PATTERN`, 4'b0110: pattern value presented on `cur_pattern` after reset.
- `GAP_CYC`, 1: idle cycles between repetitions, range 0..15.
- `CNT_W`, 8: width of the repetition count.

- `Clock`, in, 1: single clock; all logic on posedge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: request carries a pattern and count.
- `load_ready`, out, 1: block can accept a request.
- `load_pattern`, in, PATTERN_W: pattern to transmit; bit PATTERN_W-1 is sent first.
- `load_count`, in, CNT_W: number of repetitions.
- `stop_req`, in, 1: finish the current repetition, then stop.
- `x`, out, 1: serial data line; idles at 1.
- `x_valid`, out, 1: high while `x` carries a pattern or parity bit.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a transfer ends.
- `cur_pattern`, out, PATTERN_W: last accepted pattern.

## Operation
- States:
  - IDLE: `load_ready`=1.
  - SEND: shifting pattern bits.
  - PAR: parity bit; exists only with the macro.
  - GAP: `x`=1, `x_valid`=0, for GAP_CYC cycles.
- Handshake: a request is accepted when `load_valid && load_ready`.
  - On accept, latch the pattern into the shift register and `cur_pattern`.
  - Latch the count into the remaining-repetitions counter.
  - `load_ready` is 0 in every state except IDLE.
- SEND: bit index counts from PATTERN_W-1 down to 0.
  - After bit 0, go to PAR if enabled.
  - Otherwise, if remaining > 1 and no stop is latched, go to GAP (or straight to SEND if GAP_CYC=0), reload the pattern and decrement remaining.
  - Otherwise go to IDLE and pulse `done`.
- `stop_req` in SEND, PAR or GAP sets a sticky stop flag.
  - The current repetition completes in full.
  - Any pending GAP is skipped, then the block returns to IDLE with `done`.
  - The stop flag clears on the next accept.
  - `stop_req` in IDLE is ignored.
- `load_count`=0: the request is accepted but no bits are sent; `done` pulses in the cycle after accept.
- The count counter is CNT_W bits and never wraps; the maximum is 2^CNT_W-1 repetitions.
- `load_valid` while busy is ignored; the requester holds it until `load_ready`.
- Reset values: `x`=1, `x_valid`=0, `busy`=0, `done`=0, `load_ready`=1 (IDLE), `cur_pattern`=DEFAULT_PATTERN, counters 0, stop flag 0.
- Reset mid-transfer: all outputs take their reset values immediately and asynchronously. The partial pattern is abandoned.

## Timing
- Accept in cycle A.
  - Pattern bit k (MSB-first, k=0..PATTERN_W-1) is on `x` with `x_valid`=1 in cycle A+1+k.
  - `busy`=1 from A+1.
- Repetition r starts PATTERN_W(+1 with parity)+GAP_CYC cycles after repetition r-1 started.
- `done` is high one cycle after the last transmitted bit. In that same cycle `busy`=0 and `load_ready`=1, so a back-to-back accept is possible there.
- All outputs are registered; there is no combinational path from inputs to `x` or `x_valid`.

## Configuration
- `PATTERN_TX_PARITY_EN` defined: after each repetition's last bit, one PAR cycle drives the even-parity bit (XOR of the pattern) with `x_valid`=1.
- Undefined: the PAR state and parity logic are absent; SEND goes directly to GAP, SEND or IDLE.

## Structure
- Package `pattern_tx_pkg` holds:
  - the state enum (IDLE, SEND, PAR, GAP);
  - the `DEFAULT_PATTERN` constant;
  - a parity function.
- Sub-module `pattern_shift_reg` is a parallel-load, MSB-first shift register. It has load, shift-enable and reload-from-held-pattern controls, and outputs the serial bit and the bit index.
- Top level holds the FSM, the repetition and gap counters, and the stop flag.

## Test plan
- Reset release, then pattern 0110 with count 1 (no parity): `x`=0,1,1,0 in cycles A+1..A+4 with `x_valid`=1; `done` and `load_ready` are 1 in A+5; `x`=1 otherwise.
- Pattern 0110, count 3, GAP_CYC=1: bits in A+1..4, A+6..9 and A+11..14; `x`=1 with `x_valid`=0 in A+5 and A+10; `done` in A+15. A downstream detector flags three matches.
- `load_count`=0: accept in A; `done` in A+1; `x_valid` never asserted.
- Count 5 with `stop_req` pulsed during bit 2 of repetition 2: repetition 2 completes, no gap follows, `done` fires, and exactly 8 valid bits are sent in total.
- `Reset_n` low during bit 1 of repetition 1: `x`=1, `x_valid`=0 and `busy`=0 immediately; after release, `load_ready`=1 and `cur_pattern`=0110.
- With `PATTERN_TX_PARITY_EN`, pattern 0111, count 1: bits 0,1,1,1 then parity 1 in A+5; `done` in A+6.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// Shared types, reset pattern and parity helper for the pattern stream transmitter.
package pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } tx_state_e;

  localparam int unsigned PAT_MAX_W = 16;

  // The 0110 pattern the downstream detector looks for, zero-extended.
  localparam logic [PAT_MAX_W-1:0] TX_DEFAULT_PATTERN = 16'h0006;

  function automatic logic pattern_parity(input logic [PAT_MAX_W-1:0] pat);
    return ^pat;
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, MSB-first shift register with a held copy for reloading.
// bit_o is the bit that will be on the line next cycle, so the caller can register it.
module pattern_shift_reg #(
  parameter int unsigned PATTERN_W = 4,
  localparam int unsigned IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic                 shift_i,
  input  logic                 reload_i,
  output logic                 bit_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [PATTERN_W-1:0] sr_q, sr_d;
  logic [PATTERN_W-1:0] held_q, held_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    sr_d   = sr_q;
    held_d = held_q;
    idx_d  = idx_q;
    if (load_i) begin
      sr_d   = pattern_i;
      held_d = pattern_i;
      idx_d  = IDX_W'(PATTERN_W - 1);
    end else if (reload_i) begin
      sr_d  = held_q;
      idx_d = IDX_W'(PATTERN_W - 1);
    end else if (shift_i) begin
      sr_d  = {sr_q[PATTERN_W-2:0], 1'b0};
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Pattern storage is pure data; the FSM never reads it while IDLE.
  always_ff @(posedge clk_i) begin
    sr_q   <= sr_d;
    held_q <= held_d;
  end

  assign bit_o = sr_d[PATTERN_W-1];
  assign idx_o = idx_q;

endmodule

// File: rtl/pattern_stream_tx.sv
// Serial pattern transmitter: repeats a parallel pattern MSB-first with idle gaps.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit after every repetition.
module pattern_stream_tx
  import pattern_tx_pkg::*;
#(
  parameter int unsigned          PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = TX_DEFAULT_PATTERN[PATTERN_W-1:0],
  parameter int unsigned          GAP_CYC         = 1,
  parameter int unsigned          CNT_W           = 8
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [PATTERN_W-1:0] load_pattern,
  input  logic [CNT_W-1:0]     load_count,
  input  logic                 stop_req,
  output logic                 x,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done,
  output logic [PATTERN_W-1:0] cur_pattern
);

  localparam int unsigned IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int unsigned GAP_W = 4;

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 stop_q, stop_d;
  logic                 x_q, x_d;
  logic                 xv_q, xv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [PATTERN_W-1:0] cur_q, cur_d;

  logic                 accept, stop_now, more_reps, rep_end, par_bit;
  logic                 sr_load, sr_shift, sr_reload, sr_bit;
  logic [IDX_W-1:0]     sr_idx;

  pattern_shift_reg #(
    .PATTERN_W (PATTERN_W)
  ) u_shift (
    .clk_i     (Clock),
    .rst_ni    (Reset_n),
    .load_i    (sr_load),
    .pattern_i (load_pattern),
    .shift_i   (sr_shift),
    .reload_i  (sr_reload),
    .bit_o     (sr_bit),
    .idx_o     (sr_idx)
  );

  assign accept    = load_valid && ready_q;
  assign stop_now  = stop_q || stop_req;
  assign more_reps = (rem_q > CNT_W'(1)) && !stop_now;

`ifdef PATTERN_TX_PARITY_EN
  assign rep_end = (state_q == PAR);
  assign par_bit = pattern_parity(PAT_MAX_W'(cur_q));
`else
  assign rep_end = (state_q == SEND) && (sr_idx == '0);
  assign par_bit = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    stop_d    = stop_q;
    cur_d     = cur_q;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_reload = 1'b0;

    if (state_q != IDLE && stop_req) stop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_load = 1'b1;
          cur_d   = load_pattern;
          rem_d   = load_count;
          stop_d  = 1'b0;
          if (load_count == '0) done_d  = 1'b1;
          else                  state_d = SEND;
        end
      end
      SEND: begin
        if (sr_idx != '0) sr_shift = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
        else state_d = PAR;
`endif
      end
      GAP: begin
        // A stop that lands in the gap abandons the rest of the gap.
        if (stop_now) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d   = SEND;
          sr_reload = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // End of a repetition (last pattern bit, or parity bit) overrides the case above.
    if (rep_end) begin
      if (more_reps) begin
        rem_d = rem_q - CNT_W'(1);
        if (GAP_CYC == 0) begin
          state_d   = SEND;
          sr_reload = 1'b1;
        end else begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYC - 1);
        end
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // Outputs are decoded from next state so every port comes straight from a flop.
  always_comb begin
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    xv_d    = (state_d == SEND) || (state_d == PAR);
    if (state_d == SEND)     x_d = sr_bit;
    else if (state_d == PAR) x_d = par_bit;
    else                     x_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      stop_q  <= 1'b0;
      x_q     <= 1'b1;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      cur_q   <= DEFAULT_PATTERN;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      stop_q  <= stop_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      cur_q   <= cur_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = xv_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign load_ready  = ready_q;
  assign cur_pattern = cur_q;

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Scoreboard bench for pattern_stream_tx: driver pushes the expected bit stream, a monitor checks it.
module tb_pattern_stream_tx;

  localparam int PW  = 4;
  localparam int GAP = 1;
  localparam int CW  = 8;
`ifdef PATTERN_TX_PARITY_EN
  localparam int PARB = 1;
`else
  localparam int PARB = 0;
`endif
  localparam int P = PW + PARB + GAP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          stop_req = 1'b0;
  logic [PW-1:0] load_pattern = '0;
  logic [CW-1:0] load_count = '0;
  logic          load_ready, x, x_valid, busy, done;
  logic [PW-1:0] cur_pattern;

  always #5 clk = ~clk;

  pattern_stream_tx #(
    .PATTERN_W (PW),
    .GAP_CYC   (GAP),
    .CNT_W     (CW)
  ) dut (
    .Clock        (clk),
    .Reset_n      (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_count   (load_count),
    .stop_req     (stop_req),
    .x            (x),
    .x_valid      (x_valid),
    .busy         (busy),
    .done         (done),
    .cur_pattern  (cur_pattern)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bits[$];
  int exp_done[$];
  int nbits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every valid bit and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_valid) begin
        if (exp_bits.size() == 0) fail_now("unexpected_valid_bit");
        else chk("stream_bit", x, exp_bits.pop_front());
        nbits++;
      end else begin
        chk("idle_line_high", x, 1);
      end
      if (done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else chk("bits_per_transfer", nbits, exp_done.pop_front());
        nbits = 0;
      end
    end
  end

  // Reference: a stop pulsed at cycle offset s lets the repetition it lands in finish.
  task automatic model_push(input logic [PW-1:0] pat, input int cnt, input int stop_off,
                            output int reps);
    reps = cnt;
    if (stop_off > 0 && ((stop_off - 1) / P + 1) < reps) reps = (stop_off - 1) / P + 1;
    for (int r = 0; r < reps; r++) begin
      for (int b = PW - 1; b >= 0; b--) exp_bits.push_back(pat[b]);
      if (PARB != 0) exp_bits.push_back(^pat);
    end
    exp_done.push_back(reps * (PW + PARB));
  endtask

  // Called mid-cycle; returns at the negedge of the done cycle so the next call can accept there.
  task automatic run_xfer(input logic [PW-1:0] pat, input int cnt, input int stop_off,
                          input bit chk_timing);
    int  reps, exp_off, k;
    bit  got;
    load_pattern = pat;
    load_count   = CW'(cnt);
    load_valid   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (load_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      fail_now("accept_timeout");
      load_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    model_push(pat, cnt, stop_off, reps);
    chk("cur_pattern_latched", cur_pattern, pat);
    exp_off = (cnt == 0) ? 1 : (reps - 1) * P + PW + PARB + 1;
    got = 1'b0;
    for (k = 1; k <= cnt * P + 10; k++) begin
      stop_req = (k == stop_off);
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("busy_during_transfer", busy, 1);
      chk("ready_low_during_transfer", load_ready, 0);
      @(posedge clk);
      #1;
    end
    stop_req = 1'b0;
    if (!got) begin
      fail_now("done_timeout");
    end else begin
      if (chk_timing) chk("done_offset", k, exp_off);
      chk("ready_at_done", load_ready, 1);
      chk("busy_at_done", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy, cnt, s, lastbit;
    logic [PW-1:0] pat;
    bit tchk;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", x, 1);
    chk("reset_x_valid", x_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_load_ready", load_ready, 1);
    chk("reset_cur_pattern", cur_pattern, 4'b0110);
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(4'b0110, 1, 0, 1'b1);
    run_xfer(4'b0110, 3, 0, 1'b1);
    run_xfer(4'b0110, 0, 0, 1'b1);
    run_xfer(4'b1011, 5, 1 + P + 2, 1'b1);
    run_xfer(4'b0111, 1, 0, 1'b1);
    run_xfer(4'b1100, 255, 0, 1'b1);
    run_xfer(4'b0101, 255, 1 + 2 * P + 1, 1'b1);

    // Asynchronous reset while bit 1 of the first repetition is on the line.
    load_pattern = 4'b1001;
    load_count   = CW'(3);
    load_valid   = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    model_push(4'b1001, 3, 0, dummy);
    chk("cur_pattern_before_reset", cur_pattern, 4'b1001);
    @(posedge clk);
    #2;
    chk("x_valid_before_reset", x_valid, 1);
    rst_n = 1'b0;
    exp_bits.delete();
    exp_done.delete();
    nbits = 0;
    #1;
    chk("async_reset_x", x, 1);
    chk("async_reset_x_valid", x_valid, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_load_ready", load_ready, 1);
    chk("post_reset_cur_pattern", cur_pattern, 4'b0110);
    chk("post_reset_busy", busy, 0);
    run_xfer(4'b0110, 2, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      pat = PW'($urandom);
      cnt = $urandom_range(0, 5);
      s = 0;
      tchk = 1'b1;
      if (cnt > 0 && $urandom_range(0, 2) == 0) begin
        lastbit = (cnt - 1) * P + PW + PARB;
        s = $urandom_range(1, lastbit);
        tchk = (((s - 1) % P) < (PW + PARB));
      end
      run_xfer(pat, cnt, s, tchk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_bits_drained", exp_bits.size(), 0);
    chk("scoreboard_done_drained", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
